// File: rtl/uart_pkg.sv
// UART shared definitions: payload width, parity codes
// and TX controller state encoding (used by TX and RX).
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_parity.sv
// TX parity generator: byte + parity cfg -> parity bit.
// Ports: data_i byte, cfg_i parity code, par_o bit, en_o parity on.
module uart_tx_parity
  import uart_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        cfg_i,
  output logic              par_o,
  output logic              en_o
);

  // Reserved code 11 behaves like "none".
  assign en_o  = (cfg_i == PAR_ODD) || (cfg_i == PAR_EVEN);
  assign par_o = (cfg_i == PAR_ODD) ? ~^data_i : ^data_i;

endmodule

// File: rtl/uart_tx_stm.sv
// UART TX controller: FIFO pop, framing, shift register.
// Ports: cfg, FIFO pop/data, baud tick/run/clear, txd, busy/done.
module uart_tx_stm
  import uart_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              glb_clk,
  input  logic              glb_rstn,
  input  logic              Cfg_ctrl_Tx_en,
  input  logic              Cfg_ctrl_stopbit,
  input  logic [1:0]        Cfg_ctrl_paritybit,
  input  logic              FIFO_ctrl_empty,
  input  logic [DATA_W-1:0] FIFO_data_payload,
  output logic              STM_ctrl_FIFO_r_en,
  input  logic              Baud_ctrl_bit_tick,
  output logic              STM_ctrl_baud_cnt_en,
  output logic              STM_ctrl_baud_cnt_rstn,
  output logic              usr_data_txd,
  output logic              STM_status_busy,
  output logic              STM_status_done
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_q, baud_d;
  logic              par_bit;
  logic              par_on;
  logic              tick;

  uart_tx_parity u_par (
    .data_i (FIFO_data_payload),
    .cfg_i  (Cfg_ctrl_paritybit),
    .par_o  (par_bit),
    .en_o   (par_on)
  );

  assign tick = Baud_ctrl_bit_tick;

  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      txd_q    <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      baud_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      baud_q   <= baud_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    done_d   = 1'b0;
    STM_ctrl_FIFO_r_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Pop is combinational so the FIFO word is
        // valid in LOAD; held off while in reset.
        if (Cfg_ctrl_Tx_en && !FIFO_ctrl_empty
            && glb_rstn) begin
          STM_ctrl_FIFO_r_en = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shreg_d  = FIFO_data_payload;
        par_d    = par_bit;
        par_en_d = par_on;
        stop2_d  = Cfg_ctrl_stopbit;
        bcnt_d   = '0;
        state_d  = ST_START;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bcnt_q == 3'd7) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bcnt_d  = bcnt_q + 3'd1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered.
    txd_d = IDLE_LVL;
    unique case (state_d)
      ST_START:  txd_d = ~IDLE_LVL;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = IDLE_LVL;
    endcase

    busy_d = (state_d != ST_IDLE);
    baud_d = busy_d && (state_d != ST_LOAD);
  end

  assign usr_data_txd           = txd_q;
  assign STM_status_busy        = busy_q;
  assign STM_status_done        = done_q;
  assign STM_ctrl_baud_cnt_en   = baud_q;
  assign STM_ctrl_baud_cnt_rstn = baud_q;

endmodule

// File: tb/tb_uart_tx_stm.sv
// Testbench for uart_tx_stm: FIFO and baud models,
// directed frames checked bit by bit on the line.
module tb_uart_tx_stm;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       stop2;
  logic [1:0] par;
  logic       empty;
  logic [7:0] payload;
  logic       r_en;
  logic       tick;
  logic       cnt_en;
  logic       cnt_rstn;
  logic       txd;
  logic       busy;
  logic       done;
  logic       stray;

  logic [7:0] mem [0:63];
  int push_n;
  int pop_n;
  logic [3:0] bcnt;

  int n_chk;
  int n_err;
  int n_pop;
  int n_done;
  int n_busy;
  int n_bad;

  uart_tx_stm dut (
    .glb_clk                (clk),
    .glb_rstn               (rstn),
    .Cfg_ctrl_Tx_en         (en),
    .Cfg_ctrl_stopbit       (stop2),
    .Cfg_ctrl_paritybit     (par),
    .FIFO_ctrl_empty        (empty),
    .FIFO_data_payload      (payload),
    .STM_ctrl_FIFO_r_en     (r_en),
    .Baud_ctrl_bit_tick     (tick),
    .STM_ctrl_baud_cnt_en   (cnt_en),
    .STM_ctrl_baud_cnt_rstn (cnt_rstn),
    .usr_data_txd           (txd),
    .STM_status_busy        (busy),
    .STM_status_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (push_n == pop_n);
  assign tick  = (cnt_en && bcnt == 4'd15) || stray;

  always @(posedge clk) begin
    if (r_en) begin
      payload <= mem[pop_n[5:0]];
      pop_n   <= pop_n + 1;
    end
  end

  always @(posedge clk) begin
    if (!cnt_rstn) bcnt <= 4'd0;
    else if (cnt_en) bcnt <= bcnt + 4'd1;
  end

  always @(negedge clk) begin
    if (r_en) n_pop++;
    if (done) n_done++;
    if (busy) n_busy++;
    if (r_en && (busy || empty)) n_bad++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[push_n[5:0]] = b;
    push_n = push_n + 1;
  endtask

  task automatic wait_low(output logic got);
    got = 1'b0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge clk);
      if (txd === 1'b0) got = 1'b1;
    end
  endtask

  task automatic rx_frame(input int nb,
                          input logic started,
                          output logic [15:0] bits,
                          output logic stable);
    logic v;
    logic got;
    bits   = '1;
    stable = 1'b1;
    v      = 1'b1;
    got    = started;
    if (!started) begin
      wait_low(got);
      chk("rx_start", {31'd0, got}, 32'd1);
    end
    if (got) begin
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < 16; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          if (j == 0) v = txd;
          else if (txd !== v) stable = 1'b0;
          if (j == 8) bits[b] = txd;
        end
      end
    end
  endtask

  task automatic gap_len(output int g);
    logic low;
    g = 0;
    low = 1'b0;
    for (int t = 0; t < 60 && !low; t++) begin
      @(negedge clk);
      if (txd === 1'b0) low = 1'b1;
      else g++;
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic st;
    logic got;
    int p0, d0, b0, g;

    n_chk = 0; n_err = 0;
    n_pop = 0; n_done = 0;
    n_busy = 0; n_bad = 0;
    push_n = 0; pop_n = 0;
    bcnt = 4'd0; payload = 8'd0;
    rstn = 1'b0; en = 1'b0;
    stop2 = 1'b0; par = 2'b00;
    stray = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {31'd0, r_en}, 32'd0);
    chk("rst_cen", {31'd0, cnt_en}, 32'd0);
    chk("rst_crst", {31'd0, cnt_rstn}, 32'd0);
    rstn = 1'b1;

    // empty FIFO plus a stray tick: stay idle
    en = 1'b1;
    repeat (10) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_pop", n_pop, 0);
    chk("idle_busy", n_busy, 0);
    chk("idle_txd", {31'd0, txd}, 32'd1);

    // 1) 8N1 0x55
    p0 = n_pop; d0 = n_done; b0 = n_busy;
    push(8'h55);
    rx_frame(10, 1'b0, bits, st);
    chk("t1_bits", {16'd0, bits}, 32'hFEAA);
    chk("t1_stab", {31'd0, st}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t1_pop", n_pop - p0, 1);
    chk("t1_done", n_done - d0, 1);
    chk("t1_busy", n_busy - b0, 161);

    // 2) 0xA3, 2 stop bits, even then odd parity
    d0 = n_done;
    par = 2'b10; stop2 = 1'b1;
    push(8'hA3);
    rx_frame(12, 1'b0, bits, st);
    chk("t2_even", {16'd0, bits}, 32'hFD46);
    chk("t2_stab_e", {31'd0, st}, 32'd1);
    repeat (5) @(negedge clk);
    par = 2'b01;
    push(8'hA3);
    rx_frame(12, 1'b0, bits, st);
    chk("t2_odd", {16'd0, bits}, 32'hFF46);
    repeat (5) @(negedge clk);
    chk("t2_done", n_done - d0, 2);

    // 3) back-to-back 0x01, 0xFF
    par = 2'b00; stop2 = 1'b0;
    p0 = n_pop;
    push(8'h01);
    push(8'hFF);
    rx_frame(10, 1'b0, bits, st);
    chk("t3_f1", {16'd0, bits}, 32'hFE02);
    gap_len(g);
    chk("t3_gap", g, 2);
    rx_frame(10, 1'b1, bits, st);
    chk("t3_f2", {16'd0, bits}, 32'hFFFE);
    repeat (40) @(negedge clk);
    chk("t3_pop", n_pop - p0, 2);

    // 4) Tx_en dropped during data bit 3
    en = 1'b0;
    p0 = n_pop;
    push(8'hC6);
    push(8'h5A);
    en = 1'b1;
    fork
      rx_frame(10, 1'b0, bits, st);
      begin
        wait_low(got);
        repeat (16 * 4 + 4) @(negedge clk);
        en = 1'b0;
      end
    join
    chk("t4_f1", {16'd0, bits}, 32'hFF8C);
    repeat (60) @(negedge clk);
    chk("t4_pop", n_pop - p0, 1);
    chk("t4_txd", {31'd0, txd}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    en = 1'b1;
    rx_frame(10, 1'b0, bits, st);
    chk("t4_f2", {16'd0, bits}, 32'hFEB4);

    // 5) parity none -> even during data
    repeat (5) @(negedge clk);
    push(8'h0F);
    push(8'h0F);
    fork
      rx_frame(10, 1'b0, bits, st);
      begin
        wait_low(got);
        repeat (16 * 3 + 4) @(negedge clk);
        par = 2'b10;
      end
    join
    chk("t5_f1", {16'd0, bits}, 32'hFE1E);
    gap_len(g);
    chk("t5_gap", g, 2);
    rx_frame(11, 1'b1, bits, st);
    chk("t5_f2", {16'd0, bits}, 32'hFC1E);

    // 6) reset during the parity bit
    repeat (5) @(negedge clk);
    push(8'hA3);
    wait_low(got);
    repeat (16 * 9 + 4) @(negedge clk);
    chk("t6_par", {31'd0, txd}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("t6_txd", {31'd0, txd}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    push(8'h3C);
    #1;
    chk("t6_ren", {31'd0, r_en}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rx_frame(11, 1'b0, bits, st);
    chk("t6_fresh", {16'd0, bits}, 32'hFC78);
    repeat (5) @(negedge clk);
    chk("bad_pop", n_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
